// File: rtl/mem_bus_rr_arbiter.sv
// mem_bus_pkg: request/response bundles shared by the arbiter and its users.
//
// mem_bus_rr_arbiter: four-port round-robin arbiter in front of a single
// downstream memory port (L2 or memory). One transaction is in flight at a
// time. The owner keeps the bus until the downstream side returns mem_ready,
// or until the busy-cycle counter reaches TIMEOUT. On a timeout the arbiter
// completes the transaction itself with zero data and flags it.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   req1..req4   upstream requests (address, write line, load/store strobes)
//   resp1..resp4 per-requester responses (line data, one-cycle mem_ready)
//   req          downstream request, the owner's request forwarded unchanged
//   resp         downstream response
//   grant        registered one-hot owner (bit k-1 = requester k), 0 when idle
//   timeout_err  one-cycle pulse in the cycle a transaction is aborted
//   err_port     index of the most recently aborted requester

package mem_bus_pkg;
  localparam int MEM_LINE_BITS = 512;

  typedef struct packed {
    logic [57:0]              mem_addr;
    logic [MEM_LINE_BITS-1:0] mem_data_out;
    logic                     mem_req_load;
    logic                     mem_req_store;
  } mem_bus_req_t;

  typedef struct packed {
    logic [MEM_LINE_BITS-1:0] mem_data;
    logic                     mem_ready;
  } mem_bus_resp_t;
endpackage

module mem_bus_rr_arbiter
  import mem_bus_pkg::*;
#(
  parameter int CACHE_LINE_SIZE = MEM_LINE_BITS,
  parameter int TIMEOUT         = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  mem_bus_req_t  req1,
  input  mem_bus_req_t  req2,
  input  mem_bus_req_t  req3,
  input  mem_bus_req_t  req4,
  output mem_bus_resp_t resp1,
  output mem_bus_resp_t resp2,
  output mem_bus_resp_t resp3,
  output mem_bus_resp_t resp4,
  output mem_bus_req_t  req,
  input  mem_bus_resp_t resp,
  output logic [3:0]    grant,
  output logic          timeout_err,
  output logic [1:0]    err_port
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [1:0]    last;       // index of the last granted port; in BUSY it is the owner
  logic [7:0]    busy_cnt;
  logic          armed;      // low for the first edge after reset release

  mem_bus_req_t  reqs  [4];
  mem_bus_resp_t resps [4];

  logic [3:0]    active;
  logic [3:0]    cand;
  logic          busy;
  logic          done;
  logic          abort;
  logic          pick_found;
  logic [1:0]    pick_idx;
  logic [1:0]    scan_idx;
  logic [CACHE_LINE_SIZE-1:0] line_data;

  assign reqs[0] = req1;
  assign reqs[1] = req2;
  assign reqs[2] = req3;
  assign reqs[3] = req4;

  assign resp1 = resps[0];
  assign resp2 = resps[1];
  assign resp3 = resps[2];
  assign resp4 = resps[3];

  assign line_data = resp.mem_data;

  assign busy  = (state == BUSY);
  assign done  = busy && resp.mem_ready;
  assign abort = busy && !resp.mem_ready && (busy_cnt == 8'(TIMEOUT - 1));

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      active[i] = reqs[i].mem_req_load | reqs[i].mem_req_store;
    end
  end

  // The finishing owner usually still holds its request in its ready cycle;
  // masking it lets the bus pass straight to the next requester.
  assign cand = done ? (active & ~grant) : active;

  // NOTE: every variable driven here gets a default before the loop, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    scan_idx   = 2'd0;
    for (int off = 1; off <= 4; off++) begin
      scan_idx = last + 2'(off);
      if (!pick_found && cand[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge values of the other registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      last     <= 2'd3;
      busy_cnt <= 8'd0;
      err_port <= 2'd0;
      armed    <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (armed && pick_found) begin
            state    <= BUSY;
            grant    <= 4'b0001 << pick_idx;
            last     <= pick_idx;
            busy_cnt <= 8'd0;
          end
        end
        BUSY: begin
          if (done) begin
            if (pick_found) begin
              grant    <= 4'b0001 << pick_idx;
              last     <= pick_idx;
              busy_cnt <= 8'd0;
            end else begin
              state <= IDLE;
              grant <= 4'b0000;
            end
          end else if (abort) begin
            // No re-arbitration here: the bus always idles for a cycle after an abort.
            state    <= IDLE;
            grant    <= 4'b0000;
            err_port <= last;
          end else begin
            busy_cnt <= busy_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req = '0;
    if (busy) req = reqs[last];
    for (int i = 0; i < 4; i++) begin
      resps[i] = '0;
      if (busy && (last == 2'(i)) && (done || abort)) begin
        resps[i].mem_ready = 1'b1;
        resps[i].mem_data  = done ? line_data : '0;
      end
    end
  end

  assign timeout_err = abort;

endmodule

// File: doc/mem_bus_rr_arbiter.md
MEM_BUS_RR_ARBITER -- requirements
Module: mem_bus_rr_arbiter

Interface
REQ-001 The module SHALL have parameter CACHE_LINE_SIZE, default 512, giving the line width in bits of mem_data_out and mem_data.
REQ-002 The module SHALL have parameter TIMEOUT, default 255, legal range 1..255, giving the maximum number of busy cycles before a transaction is aborted.
REQ-003 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have ports req1..req4, input, mem_bus_req_t: requester k's mem_addr[57:0], mem_data_out, mem_req_load, mem_req_store.
REQ-006 The module SHALL have ports resp1..resp4, output, mem_bus_resp_t: mem_data and mem_ready returned to requester k.
REQ-007 The module SHALL have port req, output, mem_bus_req_t: the downstream (L2/memory) request.
REQ-008 The module SHALL have port resp, input, mem_bus_resp_t: the downstream response.
REQ-009 The module SHALL have port grant, output, 4 bits: one-hot registered owner (bit k-1 = requester k), 0 when idle.
REQ-010 The module SHALL have port timeout_err, output, 1 bit: single-cycle pulse on abort.
REQ-011 The module SHALL have port err_port, output, 2 bits: index (k-1) of the last aborted requester, held until the next abort.

Function
REQ-012 State SHALL be IDLE or BUSY(k), plus a 2-bit round-robin pointer last (index of the last granted port) and an 8-bit busy-cycle counter.
REQ-013 A requester SHALL be active when mem_req_load or mem_req_store is asserted.
REQ-014 In IDLE with any request active, the arbiter SHALL select the first active port scanning last+1, last+2, ... modulo 4; at the next edge it SHALL enter BUSY(k), set last=k-1, clear the counter, and set grant one-hot.
REQ-015 Grant SHALL be registered: the first downstream request cycle is the cycle after selection, with zero combinational path from reqk to grant.
REQ-016 In BUSY(k), req SHALL equal reqk field-for-field; load and store SHALL be forwarded unmodified, including both asserted.
REQ-017 When grant is 0, req SHALL drive mem_req_load=0, mem_req_store=0, mem_addr=0, mem_data_out=0.
REQ-018 In BUSY(k) with resp.mem_ready=1, respk.mem_ready SHALL be 1 and respk.mem_data=resp.mem_data in that same cycle; all other respj SHALL have mem_ready=0 and mem_data=0.
REQ-019 On a completion cycle the arbiter SHALL also arbitrate, excluding port k (masked because it still holds its request); if another port is active, the arbiter SHALL move directly to BUSY(new) with no idle bubble, otherwise to IDLE.
REQ-020 A grant SHALL be held until completion or abort, regardless of the owner's request deasserting early.
REQ-021 In BUSY with resp.mem_ready=0, the counter SHALL increment each cycle; when the counter equals TIMEOUT-1 and ready is still 0, the arbiter SHALL abort.
REQ-022 On abort, the arbiter SHALL, in that cycle, drive respk.mem_ready=1 with mem_data=0 and timeout_err=1, and load err_port=k-1.
REQ-023 On abort, the arbiter SHALL go to IDLE at the next edge, with no back-to-back grant; req SHALL be deasserted from the next cycle.
REQ-024 When resp.mem_ready=1 while IDLE, the arbiter SHALL ignore it: no respk.mem_ready and no state change.
REQ-025 With all four ports continuously active, grants SHALL rotate 1,2,3,4,1,... and each port SHALL be granted within 4 transactions.

Reset
REQ-026 While reset is asserted, the arbiter SHALL immediately (asynchronously) be IDLE with: grant=0, last=3 so port 1 has first priority, counter=0, err_port=0, timeout_err=0, all respk.mem_ready=0, and req load/store=0.
REQ-027 Reset asserted mid-transaction SHALL drop the transaction without any ready to the owner; the first grant after reset release SHALL occur no earlier than the second rising edge after release.

Verification
REQ-028 The bench SHALL cover: reset, then req2 load at addr 0x40 with L2 ready 3 cycles after grant -> grant=0010 one cycle after request, resp2.mem_ready for exactly 1 cycle carrying L2 data, then grant=0000.
REQ-029 The bench SHALL cover: all four ports requesting from reset, L2 ready 2 cycles after each grant -> grant order 0001,0010,0100,1000,0001 with no idle cycle between transactions.
REQ-030 The bench SHALL cover: port 1 holds its request one cycle past its own ready while port 3 is waiting -> port 3 is granted next, with no duplicate port 1 grant.
REQ-031 The bench SHALL cover: TIMEOUT=4, port 4 store, L2 never ready -> resp4.mem_ready=1 and timeout_err=1 on the 4th busy cycle, err_port=3, and grant=0000 the next cycle.
REQ-032 The bench SHALL cover: reset asserted mid-BUSY(2) -> grant=0000 and req load/store=0 before the next edge, and no resp2.mem_ready.
REQ-033 The bench SHALL cover: resp.mem_ready=1 injected while IDLE -> all respk.mem_ready=0 and no grant change.
